// File: rtl/hazard_detect_unit.sv
// Hazard detection for a pipeline that resolves branches in ID. It tracks rd/op for EX and MEM,
// raises load-use stalls, and selects ID-stage operand forwarding and MEM store-data forwarding.
module hazard_detect_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic [4:0] rd_ID,
  input  logic       rs1use_ID,
  input  logic       rs2use_ID,
  input  logic [1:0] hazard_optype_ID,
  input  logic       Branch_ID,
  output logic       stall_PC,
  output logic       stall_IFID,
  output logic       flush_IFID,
  output logic       flush_IDEX,
  output logic [1:0] forward_ctrl_A,
  output logic [1:0] forward_ctrl_B,
  output logic       forward_ctrl_ls
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  logic [4:0] rd_ex_r;
  logic [1:0] op_ex_r;
  logic [4:0] rd_mem_r;
  logic [1:0] op_mem_r;
  logic       ls_ex_r;
  logic       ls_mem_r;

  logic       load_use_s;
  logic       store_ls_s;

  // x0 is hardwired to zero, so it never produces a dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic       used,
                                         input logic [4:0] rs,
                                         input logic [4:0] rd_ex,
                                         input logic [1:0] op_ex,
                                         input logic [4:0] rd_mem,
                                         input logic [1:0] op_mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (!used) begin
      sel = FWD_RF;
    end else if (reg_match(rs, rd_ex) && (op_ex == OP_ALU)) begin
      sel = FWD_EX_ALU;
    end else if (reg_match(rs, rd_mem) && (op_mem == OP_ALU)) begin
      sel = FWD_MEM_ALU;
    end else if (reg_match(rs, rd_mem) && (op_mem == OP_LOAD)) begin
      sel = FWD_MEM_LD;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Hazard conditions from the ID instruction against the EX tracker
  always_comb begin
    load_use_s = 1'b0;
    store_ls_s = 1'b0;
    if (op_ex_r == OP_LOAD) begin
      load_use_s = (rs1use_ID && reg_match(rs1_ID, rd_ex_r)) ||
                   (rs2use_ID && reg_match(rs2_ID, rd_ex_r) && (hazard_optype_ID != OP_STORE));
      store_ls_s = (hazard_optype_ID == OP_STORE) && reg_match(rs2_ID, rd_ex_r);
    end else begin
      load_use_s = 1'b0;
      store_ls_s = 1'b0;
    end
  end

  // Combinational outputs, all held low during reset
  always_comb begin
    stall_PC        = 1'b0;
    stall_IFID      = 1'b0;
    flush_IFID      = 1'b0;
    flush_IDEX      = 1'b0;
    forward_ctrl_A  = FWD_RF;
    forward_ctrl_B  = FWD_RF;
    forward_ctrl_ls = 1'b0;
    if (rst) begin
      stall_PC        = 1'b0;
      stall_IFID      = 1'b0;
      flush_IFID      = 1'b0;
      flush_IDEX      = 1'b0;
      forward_ctrl_A  = FWD_RF;
      forward_ctrl_B  = FWD_RF;
      forward_ctrl_ls = 1'b0;
    end else begin
      stall_PC        = load_use_s;
      stall_IFID      = load_use_s;
      flush_IDEX      = load_use_s;
      // a pending stall defers the redirect; ID re-presents the branch next cycle
      flush_IFID      = Branch_ID && !load_use_s;
      forward_ctrl_A  = fwd_sel(rs1use_ID, rs1_ID, rd_ex_r, op_ex_r, rd_mem_r, op_mem_r);
      forward_ctrl_B  = fwd_sel(rs2use_ID, rs2_ID, rd_ex_r, op_ex_r, rd_mem_r, op_mem_r);
      forward_ctrl_ls = ls_mem_r;
    end
  end

  // Tracker pipeline: EX advances to MEM; a load-use stall injects an empty bubble into EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ex_r  <= 5'd0;
      op_ex_r  <= OP_NONE;
      rd_mem_r <= 5'd0;
      op_mem_r <= OP_NONE;
      ls_ex_r  <= 1'b0;
      ls_mem_r <= 1'b0;
    end else begin
      rd_mem_r <= rd_ex_r;
      op_mem_r <= op_ex_r;
      ls_mem_r <= ls_ex_r;
      if (load_use_s) begin
        rd_ex_r <= 5'd0;
        op_ex_r <= OP_NONE;
        ls_ex_r <= 1'b0;
      end else begin
        rd_ex_r <= rd_ID;
        op_ex_r <= hazard_optype_ID;
        ls_ex_r <= store_ls_s;
      end
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed-vector bench for hazard_detect_unit; every output is checked as one 9-bit bundle
// {stall_PC, stall_IFID, flush_IFID, flush_IDEX, fwd_A, fwd_B, fwd_ls} per cycle.
module tb_hazard_detect_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic       rs1use_ID, rs2use_ID;
  logic [1:0] hazard_optype_ID;
  logic       Branch_ID;
  logic       stall_PC, stall_IFID, flush_IFID, flush_IDEX;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls;

  int vec_cnt;
  int err_cnt;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] ALU   = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;
  localparam logic [1:0] STORE = 2'b11;
  localparam logic [8:0] IDLE  = 9'd0;

  hazard_detect_unit dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {stall_PC, stall_IFID, flush_IFID, flush_IDEX,
                forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};

  function automatic logic [8:0] mk(input logic sp, input logic si, input logic fi,
                                    input logic fx, input logic [1:0] a,
                                    input logic [1:0] b, input logic ls);
    return {sp, si, fi, fx, a, b, ls};
  endfunction

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b (sPC sIF fIF fIDEX A B ls)", tag, got, exp);
    end
  endtask

  task automatic id(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                    input logic u1, input logic u2, input logic [1:0] op, input logic br);
    rs1_ID = r1; rs2_ID = r2; rd_ID = rd;
    rs1use_ID = u1; rs2use_ID = u2;
    hazard_optype_ID = op; Branch_ID = br;
  endtask

  task automatic nop();
    id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
  endtask

  // check the settled outputs for the current ID inputs, then advance one clock
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1;
    check_val(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    id(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, LOAD, 1'b1);
    @(posedge clk); #1;
    check_val("reset_outputs", obs, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    nop();

    // ALU forwarding: EX then MEM
    id(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, ALU, 1'b0);  cyc("add_x5", IDLE);
    id(5'd5, 5'd3, 5'd6, 1'b1, 1'b1, ALU, 1'b0);  cyc("fwd_ex_alu_A", mk(0, 0, 0, 0, 2'b01, 2'b00, 0));
    id(5'd4, 5'd5, 5'd9, 1'b1, 1'b1, ALU, 1'b0);  cyc("fwd_mem_alu_B", mk(0, 0, 0, 0, 2'b00, 2'b10, 0));
    id(5'd6, 5'd9, 5'd0, 1'b0, 1'b0, NONE, 1'b0); cyc("unused_gated", IDLE);
    id(5'd9, 5'd6, 5'd0, 1'b1, 1'b1, NONE, 1'b0); cyc("fwd_mem_alu_A", mk(0, 0, 0, 0, 2'b10, 2'b00, 0));
    nop(); cyc("drain1", IDLE);
    nop(); cyc("drain2", IDLE);

    // load-use: one stall cycle, then MEM load data
    id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, LOAD, 1'b0); cyc("lw_x7", IDLE);
    id(5'd7, 5'd1, 5'd8, 1'b1, 1'b1, ALU, 1'b0);  cyc("load_use_stall", mk(1, 1, 0, 1, 2'b00, 2'b00, 0));
    id(5'd7, 5'd1, 5'd8, 1'b1, 1'b1, ALU, 1'b0);  cyc("after_stall_A11", mk(0, 0, 0, 0, 2'b11, 2'b00, 0));
    nop(); cyc("drain3", IDLE);
    nop(); cyc("drain4", IDLE);

    // load then store of the loaded register: no stall, ls forward two cycles later
    id(5'd2, 5'd0, 5'd7, 1'b1, 1'b0, LOAD, 1'b0);  cyc("lw_x7_b", IDLE);
    id(5'd2, 5'd7, 5'd0, 1'b1, 1'b1, STORE, 1'b0); cyc("sw_no_stall", IDLE);
    nop(); cyc("ls_not_yet", IDLE);
    nop(); cyc("ls_fwd", mk(0, 0, 0, 0, 2'b00, 2'b00, 1));
    nop(); cyc("ls_one_cycle", IDLE);

    // x0 never matches
    id(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, ALU, 1'b0);  cyc("addi_x0", IDLE);
    id(5'd0, 5'd3, 5'd4, 1'b1, 1'b1, ALU, 1'b0);  cyc("use_x0_alu", IDLE);
    id(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, LOAD, 1'b0); cyc("lw_x0", IDLE);
    id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, ALU, 1'b0);  cyc("use_x0_load", IDLE);
    nop(); cyc("drain5", IDLE);
    nop(); cyc("drain6", IDLE);

    // EX has priority over MEM for the same register
    id(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, LOAD, 1'b0); cyc("lw_x9", IDLE);
    id(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, ALU, 1'b0);  cyc("add_x9", IDLE);
    id(5'd9, 5'd9, 5'd0, 1'b1, 1'b1, NONE, 1'b0); cyc("ex_over_mem", mk(0, 0, 0, 0, 2'b01, 2'b01, 0));
    id(5'd0, 5'd9, 5'd0, 1'b0, 1'b1, NONE, 1'b0); cyc("mem_alu_B", mk(0, 0, 0, 0, 2'b00, 2'b10, 0));
    nop(); cyc("drain7", IDLE);
    nop(); cyc("drain8", IDLE);

    // load then branch on it: stall suppresses flush, redirect next cycle
    id(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, LOAD, 1'b0); cyc("lw_x3", IDLE);
    id(5'd3, 5'd4, 5'd0, 1'b1, 1'b1, NONE, 1'b1); cyc("beq_stall", mk(1, 1, 0, 1, 2'b00, 2'b00, 0));
    id(5'd3, 5'd4, 5'd0, 1'b1, 1'b1, NONE, 1'b1); cyc("beq_flush", mk(0, 0, 1, 0, 2'b11, 2'b00, 0));
    nop(); cyc("drain9", IDLE);
    nop(); cyc("drain10", IDLE);

    // asynchronous reset in the middle of a stall
    id(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, LOAD, 1'b0); cyc("lw_x7_c", IDLE);
    id(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, ALU, 1'b1);
    #1;
    check_val("pre_reset_stall", obs, mk(1, 1, 0, 1, 2'b00, 2'b00, 0));
    #2;
    rst = 1'b1;
    #1;
    check_val("async_reset_now", obs, IDLE);
    @(posedge clk); #1;
    check_val("reset_held", obs, IDLE);
    rst = 1'b0;
    id(5'd7, 5'd7, 5'd9, 1'b1, 1'b1, ALU, 1'b0);
    cyc("post_reset_empty", IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
